// File: rtl/aes_key_sync_loader_if.sv
// rtl/aes_key_sync_loader_if.sv - header stream and key/sync handoff interfaces for aes_key_sync_loader
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 16
);
  localparam int EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

  logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
  logic                             valid;
  logic                             rdy;
  logic                             sop;
  logic                             eop;
  logic [EMPTY_W-1:0]               empty;

  modport master (output data, valid, sop, eop, empty, input rdy);
  modport slave  (input data, valid, sop, eop, empty, output rdy);
endinterface

interface dvr_key_if;
  logic [127:0] key;
  logic [127:0] sync;
  logic         valid;
  logic         rdy;

  modport master (output key, sync, valid, input rdy);
  modport slave  (input key, sync, valid, output rdy);
endinterface

// File: rtl/aes_key_sync_loader.sv
// rtl/aes_key_sync_loader.sv - deserializes a 256-bit key/sync header and holds it for the encryptor
// Optional AES_KEY_SYNC_LOADER_SYNC_REUSE_CHECK_EN drops headers that repeat the last delivered sync.
module aes_key_sync_loader #(
  parameter int DATA_WIDTH_IN_BYTES = 16
) (
  input  logic        clk,
  input  logic        rst,
  avalon_st_if.slave  hdr_in,
  dvr_key_if.master   key_out,
  output logic        hdr_err,
  output logic        sync_reuse
);
  localparam int HDR_BEATS = 32 / DATA_WIDTH_IN_BYTES;
  localparam int DW        = 8 * DATA_WIDTH_IN_BYTES;
  localparam int CNT_W     = $clog2(HDR_BEATS) + 1;

  typedef enum logic [1:0] {IDLE, COLLECT, PRESENT} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [255:0]       sr, sr_n, shifted;
  logic [127:0]       key_q, key_n, sync_q, sync_n;
  logic               err_n;
  logic               accept;
  logic               last_beat;

`ifdef AES_KEY_SYNC_LOADER_SYNC_REUSE_CHECK_EN
  logic [127:0]       last_sync, last_sync_n;
  logic               have_prev, have_prev_n;
  logic               reuse_n;
`endif

  assign hdr_in.rdy    = (state != PRESENT);
  assign accept        = hdr_in.valid & hdr_in.rdy;
  assign key_out.valid = (state == PRESENT);
  assign key_out.key   = key_q;
  assign key_out.sync  = sync_q;

  // First byte on the wire lands in the MSB after all beats have shifted in.
  if (HDR_BEATS == 1) begin : g_one_beat
    assign shifted = hdr_in.data;
  end else begin : g_multi_beat
    assign shifted = {sr[255-DW:0], hdr_in.data};
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    sr_n      = sr;
    key_n     = key_q;
    sync_n    = sync_q;
    err_n     = 1'b0;
    last_beat = 1'b0;
`ifdef AES_KEY_SYNC_LOADER_SYNC_REUSE_CHECK_EN
    reuse_n     = 1'b0;
    last_sync_n = last_sync;
    have_prev_n = have_prev;
`endif
    unique case (state)
      IDLE: begin
        if (accept && hdr_in.sop) begin
          sr_n      = shifted;
          cnt_n     = CNT_W'(1);
          state_n   = COLLECT;
          last_beat = (HDR_BEATS == 1);
        end
      end
      COLLECT: begin
        if (accept) begin
          sr_n = shifted;
          if (hdr_in.sop) begin
            cnt_n     = CNT_W'(1);
            err_n     = 1'b1;
            last_beat = (HDR_BEATS == 1);
          end else if (cnt + CNT_W'(1) == CNT_W'(HDR_BEATS)) begin
            cnt_n     = cnt + CNT_W'(1);
            last_beat = 1'b1;
          end else if (hdr_in.eop) begin
            cnt_n   = '0;
            err_n   = 1'b1;
            state_n = IDLE;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      PRESENT: begin
        if (key_out.valid && key_out.rdy) begin
          state_n = IDLE;
`ifdef AES_KEY_SYNC_LOADER_SYNC_REUSE_CHECK_EN
          last_sync_n = sync_q;
          have_prev_n = 1'b1;
`endif
        end
      end
      default: state_n = IDLE;
    endcase

    // The final beat must close the header exactly: eop set and every byte valid.
    if (last_beat) begin
      cnt_n = '0;
      if (hdr_in.eop && (hdr_in.empty == '0)) begin
`ifdef AES_KEY_SYNC_LOADER_SYNC_REUSE_CHECK_EN
        if (have_prev && (sr_n[127:0] == last_sync)) begin
          reuse_n = 1'b1;
          state_n = IDLE;
        end else
`endif
        begin
          state_n = PRESENT;
          key_n   = sr_n[255:128];
          sync_n  = sr_n[127:0];
        end
      end else begin
        err_n   = 1'b1;
        state_n = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sr      <= '0;
      key_q   <= '0;
      sync_q  <= '0;
      hdr_err <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      sr      <= sr_n;
      key_q   <= key_n;
      sync_q  <= sync_n;
      hdr_err <= err_n;
    end
  end

`ifdef AES_KEY_SYNC_LOADER_SYNC_REUSE_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_sync  <= '0;
      have_prev  <= 1'b0;
      sync_reuse <= 1'b0;
    end else begin
      last_sync  <= last_sync_n;
      have_prev  <= have_prev_n;
      sync_reuse <= reuse_n;
    end
  end
`else
  assign sync_reuse = 1'b0;
`endif
endmodule
